// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: IDLE -> ACCESS -> RESP per access.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 1.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_wr_q, ram_wr_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    m0_ack_q, m0_ack_d;
  logic                    m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                    owner_q, owner_d;
  logic                    winner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Last-grant pointer; only consulted to break ties.
  logic                    last_q, last_d;

  always_comb begin
    winner = (m0_req && m1_req) ? ~last_q : m1_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  always_comb begin
    winner = m1_req;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      owner_q     <= owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en_d    = ram_en_q;
    ram_wr_d    = ram_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    owner_d     = owner_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          ram_en_d    = 1'b1;
          ram_wr_d    = winner ? m1_wr    : m0_wr;
          ram_addr_d  = winner ? m1_addr  : m0_addr;
          ram_wdata_d = winner ? m1_wdata : m0_wdata;
          owner_d     = winner;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d      = winner;
`endif
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // RAM output is combinational, so it is valid on this closing edge.
        ram_en_d = 1'b0;
        ram_wr_d = 1'b0;
        if (owner_q) begin
          m1_ack_d = 1'b1;
          if (!ram_wr_q) m1_rdata_d = ram_rdata;
        end else begin
          m0_ack_d = 1'b1;
          if (!ram_wr_q) m0_rdata_d = ram_rdata;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_en    = ram_en_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q == ACCESS) || (state_q == RESP);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, transaction-level reference checked every cycle,
// directed scenarios with literal expectations, then randomized two-master traffic.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          ram_en, ram_wr, busy, owner;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM: combinational read, write on clock edge; preload port for the bench.
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  bit   [DW-1:0] mem [0:(1<<AW)-1];

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
  end

  // Reference: one access occupies three cycles starting at its grant edge.
  bit   [DW-1:0] shadow [0:(1<<AW)-1];
  int            cyc = 0, free_at = 0, p_edge = 0;
  bit            p_valid = 0, p_port = 0, p_wr = 0, last_g = 1, win = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          e_en, e_wr, e_ack0, e_ack1, e_owner;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;

  always @(posedge clk) begin
    cyc++;
    if (pre_en) shadow[pre_addr] = pre_data;
    if (reset) begin
      e_en = 0; e_wr = 0; e_ack0 = 0; e_ack1 = 0; e_owner = 0;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      last_g = 1; p_valid = 0; free_at = 0;
    end else begin
      e_en = 0; e_wr = 0; e_ack0 = 0; e_ack1 = 0;
      if (p_valid && cyc == p_edge + 1) begin
        if (p_wr) shadow[p_addr] = p_wdata;
        else if (p_port) e_rd1 = shadow[p_addr];
        else e_rd0 = shadow[p_addr];
        if (p_port) e_ack1 = 1; else e_ack0 = 1;
        p_valid = 0;
      end
      if (!p_valid && cyc >= free_at && (m0_req || m1_req)) begin
        win = (m0_req && m1_req) ? (RR ? !last_g : 1'b1) : m1_req;
        p_valid = 1; p_port = win; p_edge = cyc; free_at = cyc + 3;
        p_wr    = win ? m1_wr : m0_wr;
        p_addr  = win ? m1_addr : m0_addr;
        p_wdata = win ? m1_wdata : m0_wdata;
        e_en = 1; e_wr = p_wr; e_addr = p_addr; e_wdata = p_wdata;
        e_owner = win; last_g = win;
      end
    end
  end

  always @(negedge clk) begin
    chk("ram_en",    ram_en,    reset ? 64'd0 : 64'(e_en));
    chk("ram_wr",    ram_wr,    reset ? 64'd0 : 64'(e_wr));
    chk("ram_addr",  ram_addr,  reset ? 64'd0 : 64'(e_addr));
    chk("ram_wdata", ram_wdata, reset ? 64'd0 : 64'(e_wdata));
    chk("m0_ack",    m0_ack,    reset ? 64'd0 : 64'(e_ack0));
    chk("m1_ack",    m1_ack,    reset ? 64'd0 : 64'(e_ack1));
    chk("m0_rdata",  m0_rdata,  reset ? 64'd0 : 64'(e_rd0));
    chk("m1_rdata",  m1_rdata,  reset ? 64'd0 : 64'(e_rd1));
    chk("busy",      busy,      reset ? 64'd0 : 64'(e_en | e_ack0 | e_ack1));
    chk("owner",     owner,     reset ? 64'd0 : 64'(e_owner));
  end

  task automatic drive(input bit p, input bit rq, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Starts from an IDLE cycle; lat counts edges from request to visible ack.
  task automatic do_txn(input bit p, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
    bit seen;
    @(posedge clk); #1;
    drive(p, 1, wr, a, d);
    seen = 0; lat = 0; rd = '0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if ((p ? m1_ack : m0_ack) === 1'b1) begin
        seen = 1;
        rd = p ? m1_rdata : m0_rdata;
      end
    end
    if (!seen) chk("txn_timeout", 0, 1);
    drive(p, 0, 0, '0, '0);
  endtask

  int            lat, a0, a1, c0, c1;
  logic [DW-1:0] rd, r0, r1;
  logic [3:0]    ord;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_en_busy", {ram_en, busy}, 2'b00);
    end

    do_txn(1, 1, 10'h005, 32'hDEADBEEF, lat, rd);
    chk("wr_latency", lat, 2);
    do_txn(0, 0, 10'h005, '0, lat, rd);
    chk("rd_latency", lat, 2);
    chk("rd_after_wr", rd, 32'hDEADBEEF);
    do_txn(0, 1, 10'h007, 32'h12345678, lat, rd);
    do_txn(1, 0, 10'h007, '0, lat, rd);
    chk("cross_port_rd", rd, 32'h12345678);

    // Simultaneous reads from reset.
    @(posedge clk); #1;
    do_reset();
    preload(10'h010, 32'h11);
    preload(10'h020, 32'h22);
    drive(0, 1, 0, 10'h010, '0);
    drive(1, 1, 0, 10'h020, '0);
    a0 = -1; a1 = -1; r0 = '0; r1 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (m0_ack) begin a0 = k; r0 = m0_rdata; m0_req = 0; end
      if (m1_ack) begin a1 = k; r1 = m1_rdata; m1_req = 0; end
    end
    chk("tie_m0_ack_cycle", a0, RR ? 2 : 5);
    chk("tie_m1_ack_cycle", a1, RR ? 5 : 2);
    chk("tie_m0_rdata", r0, 32'h11);
    chk("tie_m1_rdata", r1, 32'h22);

    // Continuous contention for 12 cycles.
    do_reset();
    drive(0, 1, 0, 10'h010, '0);
    drive(1, 1, 0, 10'h020, '0);
    c0 = 0; c1 = 0; ord = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (m0_ack) begin c0++; ord = {ord[2:0], 1'b0}; end
      if (m1_ack) begin c1++; ord = {ord[2:0], 1'b1}; end
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    chk("contend_m0_acks", c0, RR ? 2 : 0);
    chk("contend_m1_acks", c1, RR ? 2 : 4);
    chk("contend_order", ord, RR ? 4'b0101 : 4'b1111);

    // Reset while a write is in ACCESS.
    do_reset();
    drive(0, 1, 1, 10'h003, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("access_en", {ram_en, ram_wr}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs_zero",
        {ram_en, ram_wr, ram_addr, ram_wdata, m0_ack, m1_ack, busy, owner}, '0);
    chk("reset_rdata_zero", {m0_rdata, m1_rdata}, '0);
    drive(0, 0, 0, '0, '0);
    @(posedge clk); #1;
    chk("reset_no_ack", m0_ack, 0);
    reset = 1'b0;
    do_txn(1, 0, 10'h003, '0, lat, rd);
    chk("reset_no_commit", rd, 32'h0);

    // Randomized traffic from both masters.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (!m0_req || m0_ack) begin
        if ($urandom_range(0, 3) != 0)
          drive(0, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        else
          m0_req = 0;
      end
      if (!m1_req || m1_ack) begin
        if ($urandom_range(0, 3) != 0)
          drive(1, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        else
          m1_req = 0;
      end
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
